// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// =============================================================
// inst_fetch_unit_pkg : shared fetch constants and entry type
// Rev 1.0
// =============================================================
package inst_fetch_unit_pkg;

  localparam int          c_addr_w   = 16;
  localparam int          c_data_w   = 32;
  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]         pc;
    logic [c_data_w-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// =============================================================
// inst_fetch_unit_if : fetch-to-decode valid/ready channel
// Rev 1.0
// =============================================================
interface inst_fetch_unit_if;
  import inst_fetch_unit_pkg::*;

  logic                instr_valid;
  logic                instr_ready;
  logic [c_data_w-1:0] instr;
  logic [31:0]         instr_pc;

  modport master (
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit_skid_fifo.sv
`default_nettype none
// =============================================================
// fetch_skid_fifo : 2-entry FIFO of fetch entries with flush
// Rev 1.0
// =============================================================
module fetch_skid_fifo
  import inst_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// =============================================================
// inst_fetch_unit : PC, ROM issue/return tracking, redirect
// Rev 1.0
// =============================================================
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = c_addr_w,
  parameter int          DATA_W   = c_data_w,
  parameter logic [31:0] RESET_PC = c_reset_pc
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  inst_fetch_unit_if.master dec,
  output logic              misalign_err
);

  logic [31:0]  r_pc_issue;
  logic [31:0]  r_inflight_pc;
  logic         r_inflight;
  logic         r_misalign;

  logic [1:0]   w_count;
  logic [2:0]   w_occupancy;
  logic         w_valid;
  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  // Credit rule: FIFO entries plus the in-flight read never exceed two.
  assign w_valid      = (w_count != 2'd0) && !redirect_valid;
  assign w_pop        = w_valid && dec.instr_ready;
  assign w_push       = r_inflight && !redirect_valid;
  assign w_occupancy  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (w_occupancy < 3'd2) && !redirect_valid;
  assign w_push_entry = '{pc: r_inflight_pc, instr: rom_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_issue    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_misalign    <= 1'b0;
    end else if (redirect_valid) begin
      r_pc_issue <= {redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc_issue;
      r_pc_issue    <= r_pc_issue + 32'd4;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .count     (w_count),
    .head      (w_head)
  );

  assign rom_address     = r_pc_issue[ADDR_W+1:2];
  assign dec.instr_valid = w_valid;
  assign dec.instr       = w_head.instr;
  assign dec.instr_pc    = w_head.pc;
  assign misalign_err    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// =============================================================
// tb_inst_fetch_unit : directed + random stream check vs PC model
// Rev 1.0
// =============================================================
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rom_address;
  logic [31:0] rom_q;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [15:0] rom_addr_q;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: next PC decode should see, edges since (re)start, sticky flag
  logic [31:0] exp_pc;
  int          since;
  logic        exp_mis;
  logic        prev_stall;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;

  inst_fetch_unit_if dec_if ();

  inst_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_address    (rom_address),
    .rom_q          (rom_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec_if.master),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_addr_q <= rom_address;
  assign rom_q = 32'h1000_0000 + {16'h0000, rom_addr_q};

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return 32'h1000_0000 + {16'h0000, pc[17:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    dec_if.instr_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_instr_valid", {31'b0, dec_if.instr_valid}, 32'd0);
    chk("rst_instr", dec_if.instr, 32'd0);
    chk("rst_instr_pc", dec_if.instr_pc, 32'd0);
    chk("rst_rom_address", {16'h0, rom_address}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
    rst_n      = 1'b1;
    exp_pc     = 32'h0;
    since      = 0;
    exp_mis    = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic exp_valid;
    dec_if.instr_ready = rdy;
    redirect_valid     = rv;
    redirect_pc        = rpc;
    @(negedge clk);
    exp_valid = (since >= 2) && !rv;
    chk("instr_valid", {31'b0, dec_if.instr_valid}, {31'b0, exp_valid});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
    if (prev_stall && dec_if.instr_valid) begin
      chk("hold_pc", dec_if.instr_pc, prev_pc);
      chk("hold_instr", dec_if.instr, prev_instr);
    end
    if (dec_if.instr_valid && rdy) begin
      chk("xfer_pc", dec_if.instr_pc, exp_pc);
      chk("xfer_instr", dec_if.instr, exp_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    prev_stall = dec_if.instr_valid && !rdy;
    prev_pc    = dec_if.instr_pc;
    prev_instr = dec_if.instr;
    @(posedge clk);
    #1;
    if (rv) begin
      exp_pc     = {rpc[31:2], 2'b00};
      since      = 0;
      prev_stall = 1'b0;
      if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
    end else if (since < 2) begin
      since++;
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'h0;
    dec_if.instr_ready = 1'b0;
    exp_pc             = 32'h0;
    since              = 0;
    exp_mis            = 1'b0;
    prev_stall         = 1'b0;
    prev_pc            = 32'h0;
    prev_instr         = 32'h0;
    @(posedge clk);
    #1;

    // Startup latency and back-to-back stream
    do_reset();
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Back-pressure: issue stops once FIFO plus in-flight reach two
    do_reset();
    repeat (7) cycle(1'b0, 1'b0, 32'h0);
    chk("stall_rom_address", {16'h0, rom_address}, 32'h0000_0002);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with full FIFO discards wrong-path words
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0040);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect sets sticky flag, fetch aligned
    cycle(1'b1, 1'b1, 32'h0000_0042);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // ROM word-address wrap
    cycle(1'b1, 1'b1, 32'h0003_FFFC);
    chk("wrap_rom_hi", {16'h0, rom_address}, 32'h0000_FFFF);
    cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_rom_lo", {16'h0, rom_address}, 32'h0000_0000);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Mid-stream reset with full FIFO
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic        r_rdy;
      logic        r_rv;
      logic [31:0] r_pc;
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = ($urandom_range(0, 15) == 0);
      r_pc  = $urandom;
      if ($urandom_range(0, 1) == 0) r_pc[1:0] = 2'b00;
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle(r_rdy, r_rv, r_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
